// File: rtl/gpio_debounce_pkg.sv
// Shared types and helpers for the GPIO input debouncer.
package gpio_debounce_pkg;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_SETTLE = 1'b1
   } deb_state_t;

   // Ceiling log2, usable in constant expressions; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/gpio_debounce_chan.sv
// One debounce channel: 2-flop synchroniser, settle FSM and clean/rise/fall registers.
module gpio_debounce_chan
   import gpio_debounce_pkg::*;
#(
   parameter int unsigned stable_ticks = 10,
   parameter logic        idle_level   = 1'b0
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic raw_in,
   input  logic tick,
   output logic clean_out,
   output logic rise,
   output logic fall
);

   localparam int unsigned cnt_w = clog2(stable_ticks) + 1;
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(stable_ticks - 1);

   logic             sync_d, sync_q;
   deb_state_t       state, state_nxt;
   logic [cnt_w-1:0] cnt, cnt_nxt;
   logic             clean_nxt, rise_nxt, fall_nxt;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_d    <= idle_level;
         sync_q    <= idle_level;
         state     <= ST_STABLE;
         cnt       <= '0;
         clean_out <= idle_level;
         rise      <= 1'b0;
         fall      <= 1'b0;
      end else begin
         sync_d    <= raw_in;
         sync_q    <= sync_d;
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         clean_out <= clean_nxt;
         rise      <= rise_nxt;
         fall      <= fall_nxt;
      end
   end

   // A bounce back to the clean level always wins over a same-cycle commit.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clean_nxt = clean_out;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      unique case (state)
         ST_STABLE: begin
            if (sync_q != clean_out) begin
               state_nxt = ST_SETTLE;
               cnt_nxt   = '0;
            end
         end
         ST_SETTLE: begin
            if (sync_q == clean_out) begin
               state_nxt = ST_STABLE;
               cnt_nxt   = '0;
            end else if (tick && cnt == cnt_last) begin
               state_nxt = ST_STABLE;
               cnt_nxt   = '0;
               clean_nxt = sync_q;
               rise_nxt  = sync_q;
               fall_nxt  = ~sync_q;
            end else if (tick) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/gpio_debounce.sv
// Debounces ninputs raw pad inputs against one shared prescaled time-base.
module gpio_debounce
   import gpio_debounce_pkg::*;
#(
   parameter int unsigned         ninputs      = 16,
   parameter logic [31:0]         clk_freq     = 32'd100000000,
   parameter int unsigned         tick_us      = 1000,
   parameter int unsigned         stable_ticks = 10,
   parameter logic [ninputs-1:0]  idle_level   = {ninputs{1'b0}}
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [ninputs-1:0] raw_in,
   output logic [ninputs-1:0] clean_out,
   output logic [ninputs-1:0] rise,
   output logic [ninputs-1:0] fall,
   output logic               tick
);

   localparam logic [31:0] div_raw = (clk_freq / 32'd1000000) * 32'(tick_us);
   localparam logic [31:0] div_last = (div_raw == 32'd0) ? 32'd0 : div_raw - 32'd1;

   logic [31:0] presc;

   // tick is registered on the wrap, so the first one lands div cycles after reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         presc <= '0;
         tick  <= 1'b0;
      end else if (presc == div_last) begin
         presc <= '0;
         tick  <= 1'b1;
      end else begin
         presc <= presc + 32'd1;
         tick  <= 1'b0;
      end
   end

   for (genvar g = 0; g < ninputs; g++) begin : g_chan
      gpio_debounce_chan #(
         .stable_ticks (stable_ticks),
         .idle_level   (idle_level[g])
      ) u_chan (
         .sys_clk   (sys_clk),
         .sys_rst_n (sys_rst_n),
         .raw_in    (raw_in[g]),
         .tick      (tick),
         .clean_out (clean_out[g]),
         .rise      (rise[g]),
         .fall      (fall[g])
      );
   end

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce (DIV=10, stable_ticks=4) plus a stable_ticks=1 instance.
module tb_gpio_debounce;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [3:0] raw_in = 4'h0, raw1 = 4'h0;
   logic [3:0] clean_out, rise, fall, clean1, rise1, fall1;
   logic       tick, tick1;

   int nvec = 0, nerr = 0;
   int rise_cnt[4], fall_cnt[4];
   int both_cnt = 0;

   gpio_debounce #(.ninputs(4), .clk_freq(32'd10000000), .tick_us(1),
                   .stable_ticks(4), .idle_level(4'b0000)) u_dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .raw_in(raw_in),
      .clean_out(clean_out), .rise(rise), .fall(fall), .tick(tick));

   gpio_debounce #(.ninputs(4), .clk_freq(32'd10000000), .tick_us(1),
                   .stable_ticks(1), .idle_level(4'b0000)) u_dut1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .raw_in(raw1),
      .clean_out(clean1), .rise(rise1), .fall(fall1), .tick(tick1));

   always #5 sys_clk = ~sys_clk;

   initial for (int c = 0; c < 4; c++) begin rise_cnt[c] = 0; fall_cnt[c] = 0; end

   always @(negedge sys_clk) begin
      for (int c = 0; c < 4; c++) begin
         if (rise[c]) rise_cnt[c]++;
         if (fall[c]) fall_cnt[c]++;
      end
      if ((rise & fall) != 4'h0) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n, r0, f0, r1, f1;

      // reset held with all pads high
      raw_in = 4'hF;
      #3;
      chk("rst_clean_t0", 32'(clean_out), 32'h0);
      repeat (4) @(negedge sys_clk);
      chk("rst_clean", 32'(clean_out), 32'h0);
      chk("rst_rise_fall", 32'({rise, fall}), 32'h0);
      chk("rst_tick", 32'(tick), 32'h0);

      // release; first tick lands DIV cycles later, then every DIV cycles
      raw_in = 4'h0;
      sys_rst_n = 1'b1;
      n = 0;
      do begin @(negedge sys_clk); n++; end while (!tick && n < 30);
      chk("first_tick_lat", n, 10);
      n = 0;
      do begin @(negedge sys_clk); n++; end while (!tick && n < 30);
      chk("tick_period", n, 10);
      @(negedge sys_clk);
      chk("tick_one_cycle", 32'(tick), 32'h0);

      // clean press on channel 0
      repeat (3) @(negedge sys_clk);
      raw_in[0] = 1'b1;
      n = 0;
      do begin @(negedge sys_clk); n++; end while (!clean_out[0] && n < 60);
      chk("press_lat_window", 32'(n >= 32 && n <= 42), 32'h1);
      chk("press_rise", 32'(rise[0]), 32'h1);
      chk("press_no_fall", 32'(fall[0]), 32'h0);
      @(negedge sys_clk);
      chk("press_rise_1cyc", 32'(rise[0]), 32'h0);
      chk("press_rise_count", rise_cnt[0], 1);

      // stable_ticks=1 instance: accepted on first tick after sync
      raw1[0] = 1'b1;
      n = 0;
      do begin @(negedge sys_clk); n++; end while (!clean1[0] && n < 30);
      chk("st1_lat_window", 32'(n >= 3 && n <= 12), 32'h1);
      chk("st1_rise", 32'(rise1[0]), 32'h1);

      // bounce rejection on channel 1
      r1 = rise_cnt[1]; f1 = fall_cnt[1];
      for (int i = 0; i < 200; i++) begin
         if (i % 15 == 0) raw_in[1] = ~raw_in[1];
         @(negedge sys_clk);
      end
      raw_in[1] = 1'b0;
      repeat (60) @(negedge sys_clk);
      chk("bounce_clean", 32'(clean_out[1]), 32'h0);
      chk("bounce_no_events", 32'(rise_cnt[1] - r1 + fall_cnt[1] - f1), 32'h0);
      chk("bounce_ch0_held", 32'(clean_out[0]), 32'h1);

      // simultaneous press on channels 2 and 3
      raw_in[3:2] = 2'b11;
      n = 0;
      do begin @(negedge sys_clk); n++; end while (clean_out[3:2] == 2'b00 && n < 60);
      chk("simul_clean", 32'(clean_out[3:2]), 32'h3);
      chk("simul_rise", 32'(rise[3:2]), 32'h3);
      chk("simul_lat_window", 32'(n >= 32 && n <= 42), 32'h1);

      // release channel 2 only
      repeat (5) @(negedge sys_clk);
      r0 = rise_cnt[3]; f0 = fall_cnt[3];
      raw_in[2] = 1'b0;
      n = 0;
      do begin @(negedge sys_clk); n++; end while (clean_out[2] && n < 60);
      chk("release_clean2", 32'(clean_out[2]), 32'h0);
      chk("release_fall2", 32'(fall[2]), 32'h1);
      chk("release_no_rise2", 32'(rise[2]), 32'h0);
      chk("release_clean3", 32'(clean_out[3]), 32'h1);
      @(negedge sys_clk);
      chk("release_fall_1cyc", 32'(fall[2]), 32'h0);
      chk("release_ch3_quiet", 32'(rise_cnt[3] - r0 + fall_cnt[3] - f0), 32'h0);
      chk("never_rise_and_fall", both_cnt, 0);

      // asynchronous reset mid-cycle, no clock edge
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("async_rst_clean", 32'(clean_out), 32'h0);
      chk("async_rst_tick", 32'(tick), 32'h0);
      @(negedge sys_clk);
      raw_in = 4'h0;
      raw1 = 4'h0;
      sys_rst_n = 1'b1;
      repeat (80) @(negedge sys_clk);
      chk("idle_after_rst", 32'(clean_out), 32'h0);

      // reset during settling discards the pending change
      r0 = rise_cnt[0];
      raw_in[0] = 1'b1;
      repeat (25) @(negedge sys_clk);
      chk("midsettle_not_yet", 32'(clean_out[0]), 32'h0);
      sys_rst_n = 1'b0;
      #1;
      chk("midsettle_rst_clean", 32'(clean_out[0]), 32'h0);
      repeat (2) @(negedge sys_clk);
      chk("midsettle_no_rise", rise_cnt[0] - r0, 0);
      sys_rst_n = 1'b1;
      n = 0;
      do begin @(negedge sys_clk); n++; end while (!clean_out[0] && n < 60);
      chk("midsettle_fresh_lat", 32'(n >= 32 && n <= 42), 32'h1);
      chk("midsettle_rise", 32'(rise[0]), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
